credit_game_sequencer: RTL

CREDIT_GAME_SEQUENCER -- requirements
Module: credit_game_sequencer

---
 rtl/credit_game_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/credit_game_sequencer.sv
// Purpose : coin/credit bookkeeping and ATTRACT->SERVE->PLAY->OVER game sequencing for a 1..4 player table.
// Latency : pin falling edge to state/credit effect is 3 cycles (2-flop sync + edge detect); BALL_LOST/BONUS_CREDIT act next edge.
// Backpr. : none; every event is consumed the cycle it is detected, and excess credits saturate at MAX_CREDITS.
//
// Ports:
//   CLK_SRC, RESET_N         clock, async active-low reset
//   COIN_N, START_N, SERVE_N asynchronous active-low switches (synchronised here)
//   CREDIT_MODE              00 1c/1cr, 01 1c/2cr, 10 2c/1cr, 11 free play
//   BALLS_PER_GAME           balls per player (0 means 1), latched at game start
//   BALL_LOST, BONUS_CREDIT  single-cycle pulses from playfield logic
//   CREDITS .. COIN_SOUND    status levels and single-cycle pulses
module credit_game_sequencer #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_COINS   = 2,
    parameter int CREDIT_W    = 4,
    parameter int MAX_CREDITS = 15
) (
    input  logic                   CLK_SRC,
    input  logic                   RESET_N,
    input  logic [NUM_COINS-1:0]   COIN_N,
    input  logic [NUM_PLAYERS-1:0] START_N,
    input  logic                   SERVE_N,
    input  logic [1:0]             CREDIT_MODE,
    input  logic [2:0]             BALLS_PER_GAME,
    input  logic                   BALL_LOST,
    input  logic                   BONUS_CREDIT,
    output logic [CREDIT_W-1:0]    CREDITS,
    output logic                   ATTRACT,
    output logic                   START_GAME,
    output logic                   SERVE_WAIT,
    output logic [1:0]             CUR_PLAYER,
    output logic [2:0]             NUM_IN_GAME,
    output logic [2:0]             BALL_NUM,
    output logic [NUM_PLAYERS-1:0] START_LAMP,
    output logic                   GAME_OVER,
    output logic                   COIN_SOUND
);

    localparam int NB = NUM_COINS + NUM_PLAYERS + 1;
    localparam int SW = CREDIT_W + 6;

    typedef enum logic [1:0] {S_ATTRACT, S_SERVE, S_PLAY, S_OVER} state_t;

    state_t                   state, state_nxt;
    logic [NB-1:0]            pins, sync1, sync2, seen_hi, events;
    logic [1:0]               warm;
    logic [NUM_COINS-1:0]     coin_ev;
    logic [NUM_PLAYERS-1:0]   start_ev;
    logic                     serve_ev;
    logic                     half, half_nxt;
    logic [4:0]               coin_add;
    logic                     free_play;
    logic                     start_ok, take_start;
    logic [2:0]               start_sel;
    logic [2:0]               deduct;
    logic [SW-1:0]            sum;
    logic [CREDIT_W-1:0]      credits_nxt;
    logic [2:0]               balls_game;
    logic                     last_player, game_done;

    // ---------------- input synchronisers and falling-edge detect ----------------
    assign pins = {SERVE_N, START_N, COIN_N};

    // seen_hi only ever holds genuinely sampled pin data: it stays 0 until the
    // sync chain has flushed its reset value, so a switch held low across reset
    // release never looks like a 1->0 transition.
    always_ff @(posedge CLK_SRC or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1   <= '1;
            sync2   <= '1;
            seen_hi <= '0;
            warm    <= 2'd0;
        end else begin
            sync1   <= pins;
            sync2   <= sync1;
            seen_hi <= (warm == 2'd2) ? sync2 : '0;
            if (warm != 2'd2) warm <= warm + 2'd1;
        end
    end

    assign events   = seen_hi & ~sync2;
    assign coin_ev  = events[NUM_COINS-1:0];
    assign start_ev = events[NUM_COINS +: NUM_PLAYERS];
    assign serve_ev = events[NB-1];

    assign free_play = (CREDIT_MODE == 2'b11);

    // ---------------- credit add (coins in ascending channel order) ----------------
    always_comb begin
        coin_add = 5'd0;
        half_nxt = half;
        for (int c = 0; c < NUM_COINS; c++) begin
            if (coin_ev[c]) begin
                case (CREDIT_MODE)
                    2'b00: coin_add = coin_add + 5'd1;
                    2'b01: coin_add = coin_add + 5'd2;
                    2'b10: begin
                        if (half_nxt) begin
                            coin_add = coin_add + 5'd1;
                            half_nxt = 1'b0;
                        end else begin
                            half_nxt = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (BONUS_CREDIT && !free_play) coin_add = coin_add + 5'd1;
    end

    // ---------------- start qualification: highest qualifying bit wins ----------------
    always_comb begin
        start_ok  = 1'b0;
        start_sel = 3'd0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (start_ev[k] && (free_play || int'(CREDITS) >= k + 1)) begin
                start_ok  = 1'b1;
                start_sel = 3'(k + 1);
            end
        end
    end

    assign take_start  = (state == S_ATTRACT) && start_ok;
    assign deduct      = (take_start && !free_play) ? start_sel : 3'd0;
    assign sum         = SW'(CREDITS) - SW'(deduct) + SW'(coin_add);
    assign credits_nxt = (sum > SW'(MAX_CREDITS)) ? CREDIT_W'(MAX_CREDITS) : sum[CREDIT_W-1:0];

    assign last_player = ({1'b0, CUR_PLAYER} == NUM_IN_GAME - 3'd1);
    assign game_done   = last_player && (BALL_NUM == balls_game);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK_SRC or negedge RESET_N) begin
        if (!RESET_N) state <= S_ATTRACT;
        else          state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_ATTRACT: if (start_ok) state_nxt = S_SERVE;
            S_SERVE:   if (serve_ev) state_nxt = S_PLAY;
            S_PLAY:    if (BALL_LOST) state_nxt = game_done ? S_OVER : S_SERVE;
            S_OVER:    state_nxt = S_ATTRACT;
            default:   state_nxt = S_ATTRACT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ATTRACT    = (state == S_ATTRACT);
        SERVE_WAIT = (state == S_SERVE);
        GAME_OVER  = (state == S_OVER);
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            START_LAMP[k] = ATTRACT && (free_play || int'(CREDITS) >= k + 1);
        end
    end

    // ---------------- credits, game counters, pulses ----------------
    always_ff @(posedge CLK_SRC or negedge RESET_N) begin
        if (!RESET_N) begin
            CREDITS     <= '0;
            half        <= 1'b0;
            NUM_IN_GAME <= 3'd0;
            CUR_PLAYER  <= 2'd0;
            BALL_NUM    <= 3'd0;
            balls_game  <= 3'd1;
            START_GAME  <= 1'b0;
            COIN_SOUND  <= 1'b0;
        end else begin
            CREDITS    <= credits_nxt;
            half       <= half_nxt;
            START_GAME <= take_start;
            COIN_SOUND <= |coin_ev;
            if (take_start) begin
                NUM_IN_GAME <= start_sel;
                CUR_PLAYER  <= 2'd0;
                BALL_NUM    <= 3'd1;
                balls_game  <= (BALLS_PER_GAME == 3'd0) ? 3'd1 : BALLS_PER_GAME;
            end else if (state == S_PLAY && BALL_LOST && !game_done) begin
                if (!last_player) begin
                    CUR_PLAYER <= CUR_PLAYER + 2'd1;
                end else begin
                    CUR_PLAYER <= 2'd0;
                    BALL_NUM   <= BALL_NUM + 3'd1;
                end
            end else if (state == S_OVER) begin
                NUM_IN_GAME <= 3'd0;
                CUR_PLAYER  <= 2'd0;
                BALL_NUM    <= 3'd0;
            end
        end
    end

endmodule
